// File: rtl/oldest_excp_track.sv
// Tracks the oldest pending exception reported by the writeback ports and holds it until the ROB
// takes it. Records can be replaced by older reports, or discarded by a squash or a flush.
module oldest_excp_track #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CAUSE_W   = 5,
    parameter int unsigned TVAL_W    = 64,
    parameter int unsigned ROB_IDX_W = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [WIDTH-1:0]                    i_excp_vld,
    input  logic [WIDTH-1:0][ROB_IDX_W:0]       i_excp_rob_idx,
    input  logic [WIDTH-1:0][CAUSE_W-1:0]       i_excp_cause,
    input  logic [WIDTH-1:0][TVAL_W-1:0]        i_excp_tval,
    input  logic                                i_flush,
    input  logic                                i_squash_vld,
    input  logic [ROB_IDX_W:0]                  i_squash_rob_idx,
    input  logic                                i_commit_ack,
    output logic                                o_vld,
    output logic [ROB_IDX_W:0]                  o_rob_idx,
    output logic [CAUSE_W-1:0]                  o_cause,
    output logic [TVAL_W-1:0]                   o_tval,
    output logic [15:0]                         o_excp_cnt
);

    typedef enum logic [0:0] {StEmpty, StHeld} state_e;

    state_e               state;
    logic                 sel_vld;
    logic [ROB_IDX_W:0]   sel_idx;
    logic [CAUSE_W-1:0]   sel_cause;
    logic [TVAL_W-1:0]    sel_tval;
    logic                 rec_kill;
    logic                 held_drop;
    logic                 load;

    // rob index is {flag, idx}; the flag flips on every wrap of the idx field.
    function automatic logic is_older(input logic [ROB_IDX_W:0] a, input logic [ROB_IDX_W:0] b);
        if (a[ROB_IDX_W] == b[ROB_IDX_W]) begin
            return a[ROB_IDX_W-1:0] < b[ROB_IDX_W-1:0];
        end
        return a[ROB_IDX_W-1:0] > b[ROB_IDX_W-1:0];
    endfunction

    // Oldest surviving report; strict comparison keeps the lower port on a tie.
    always_comb begin
        sel_vld   = 1'b0;
        sel_idx   = '0;
        sel_cause = '0;
        sel_tval  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i_excp_vld[i] &&
                !(i_squash_vld && !is_older(i_excp_rob_idx[i], i_squash_rob_idx)) &&
                (!sel_vld || is_older(i_excp_rob_idx[i], sel_idx))) begin
                sel_vld   = 1'b1;
                sel_idx   = i_excp_rob_idx[i];
                sel_cause = i_excp_cause[i];
                sel_tval  = i_excp_tval[i];
            end
        end
    end

    always_comb begin
        rec_kill  = i_squash_vld && !is_older(o_rob_idx, i_squash_rob_idx);
        held_drop = i_commit_ack || rec_kill;
        load      = sel_vld &&
                    ((state == StEmpty) || held_drop || is_older(sel_idx, o_rob_idx));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= StEmpty;
            o_vld      <= 1'b0;
            o_rob_idx  <= '0;
            o_cause    <= '0;
            o_tval     <= '0;
            o_excp_cnt <= '0;
        end else if (i_flush) begin
            state <= StEmpty;
            o_vld <= 1'b0;
        end else begin
            unique case (state)
                StEmpty: begin
                    if (sel_vld) begin
                        state <= StHeld;
                        o_vld <= 1'b1;
                    end
                end
                StHeld: begin
                    if (i_commit_ack && (o_excp_cnt != 16'hFFFF)) begin
                        o_excp_cnt <= o_excp_cnt + 16'd1;
                    end
                    if (held_drop && !sel_vld) begin
                        state <= StEmpty;
                        o_vld <= 1'b0;
                    end
                end
                default: begin
                    state <= StEmpty;
                    o_vld <= 1'b0;
                end
            endcase
            if (load) begin
                o_rob_idx <= sel_idx;
                o_cause   <= sel_cause;
                o_tval    <= sel_tval;
            end
        end
    end

endmodule
